// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry 2-bit saturating counters.
//
// Fetch side looks up PCF_i combinationally and returns a predicted next PC.
// Execute side takes the resolved branch/jump outcome, updates the table on
// the rising edge, and combinationally flags mispredictions with the recovery
// PC. Two saturating statistics counters track updates and mispredictions.
//
// Ports:
//   clk_i, rst_i                        clock, asynchronous active-high reset
//   PCF_i                               Fetch PC to look up
//   PredTakenF_o, PredTargetF_o         Fetch prediction (target valid when taken)
//   UpdateE_i                           a branch/jump resolved in Execute
//   PCE_i, IsJumpE_i, TakenE_i, TargetE_i    resolved instruction and outcome
//   PredTakenE_i, PredTargetE_i         Fetch prediction carried to Execute
//   MispredictE_o, RecoverPCE_o         flush request and correct next PC
//   BranchCount_o, MispredCount_o       saturating statistics
//
// ENTRIES must be a power of two and at least 2.

module branch_predictor #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // Fetch lookup
  input  logic [PC_WIDTH-1:0]  PCF_i,
  output logic                 PredTakenF_o,
  output logic [PC_WIDTH-1:0]  PredTargetF_o,
  // Execute update
  input  logic                 UpdateE_i,
  input  logic [PC_WIDTH-1:0]  PCE_i,
  input  logic                 IsJumpE_i,
  input  logic                 TakenE_i,
  input  logic [PC_WIDTH-1:0]  TargetE_i,
  input  logic                 PredTakenE_i,
  input  logic [PC_WIDTH-1:0]  PredTargetE_i,
  // Recovery
  output logic                 MispredictE_o,
  output logic [PC_WIDTH-1:0]  RecoverPCE_o,
  // Statistics
  output logic [CNT_WIDTH-1:0] BranchCount_o,
  output logic [CNT_WIDTH-1:0] MispredCount_o
);

  localparam int unsigned IB    = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_WIDTH - IB - 2;

  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  jump_q;
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  // PC[1:0] never contributes to index or tag.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF_i[1:0], PCE_i[1:0]};

  // ---------------------------------------------------------------------------
  // Fetch lookup
  // ---------------------------------------------------------------------------
  logic [IB-1:0]    idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;

  assign idx_f = PCF_i[IB+1:2];
  assign tag_f = PCF_i[PC_WIDTH-1:IB+2];
  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

  // Jumps are always predicted taken regardless of the counter. Gating with
  // rst_i makes the output drop the instant reset asserts.
  always_comb begin
    PredTakenF_o  = 1'b0;
    PredTargetF_o = '0;
    if (!rst_i) begin
      PredTakenF_o  = hit_f && (jump_q[idx_f] || ctr_q[idx_f][1]);
      PredTargetF_o = target_q[idx_f];
    end
  end

  // ---------------------------------------------------------------------------
  // Execute update: compute the next contents of the indexed entry
  // ---------------------------------------------------------------------------
  logic [IB-1:0]       idx_e;
  logic [TAG_W-1:0]    tag_e;
  logic                hit_e;
  logic [1:0]          ctr_e;
  logic                we_e;
  logic [PC_WIDTH-1:0] new_target;
  logic                new_jump;
  logic [1:0]          new_ctr;

  assign idx_e = PCE_i[IB+1:2];
  assign tag_e = PCE_i[PC_WIDTH-1:IB+2];
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign ctr_e = ctr_q[idx_e];

  // A not-taken miss leaves the table alone; everything else writes the entry.
  assign we_e = UpdateE_i && (hit_e || TakenE_i);

  always_comb begin
    new_target = target_q[idx_e];
    new_jump   = IsJumpE_i;
    new_ctr    = ctr_e;
    if (hit_e) begin
      if (TakenE_i) begin
        new_target = TargetE_i;
        new_ctr    = (ctr_e == 2'b11) ? 2'b11 : ctr_e + 2'd1;
      end else begin
        new_ctr    = (ctr_e == 2'b00) ? 2'b00 : ctr_e - 2'd1;
      end
    end else begin
      // Allocation overwrites whatever occupant shares the index.
      new_target = TargetE_i;
      new_ctr    = CTR_ALLOC;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      jump_q  <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else if (we_e) begin
      valid_q[idx_e]  <= 1'b1;
      jump_q[idx_e]   <= new_jump;
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= new_target;
      ctr_q[idx_e]    <= new_ctr;
    end
  end

  // ---------------------------------------------------------------------------
  // Misprediction detection and recovery PC
  // ---------------------------------------------------------------------------
  logic dir_wrong;
  logic tgt_wrong;

  assign dir_wrong     = (PredTakenE_i != TakenE_i);
  assign tgt_wrong     = TakenE_i && (PredTargetE_i != TargetE_i);
  assign MispredictE_o = UpdateE_i && (dir_wrong || tgt_wrong);
  assign RecoverPCE_o  = TakenE_i ? TargetE_i : (PCE_i + PC_WIDTH'(4));

  // ---------------------------------------------------------------------------
  // Saturating statistics
  // ---------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] branch_cnt_q;
  logic [CNT_WIDTH-1:0] mispred_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (UpdateE_i && !(&branch_cnt_q)) begin
        branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
      end
      if (MispredictE_o && !(&mispred_cnt_q)) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign BranchCount_o  = branch_cnt_q;
  assign MispredCount_o = mispred_cnt_q;

endmodule
